// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: memory endpoint of the 12-bit multiplexed CPU bus, with a host preload port.
// Optional two-beat 12-bit stores are enabled by defining MEM_BUS_WIDE_WRITE_EN.
//   state     | meaning
//   IDLE      | no store in flight; bus reads decode addr_data directly
//   ADDR_HELD | store address captured in addr_q, waiting for the commit beat
//   DATA_LO   | low six data bits captured in lo_q, waiting for the high beat (wide only)
module mem_bus_bridge #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [11:0]      bus_in,
  output logic [11:0]      bus_out,
  input  logic             ld_valid,
  input  logic [9:0]       ld_addr,
  input  logic [11:0]      ld_data,
  output logic             ld_ready,
  output logic             proto_err,
  output logic [CNT_W-1:0] store_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef MEM_BUS_WIDE_WRITE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR_HELD = 2'd1, DATA_LO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR_HELD = 2'd1} state_t;
`endif

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic [11:0]     mem [DEPTH];
`ifdef MEM_BUS_WIDE_WRITE_EN
  logic [5:0]      lo_q;
`endif

  logic            rw;
  logic            commit;
  logic [9:0]      addr_data;
  logic [AW-1:0]   bus_addr;
  logic            bus_we;
  logic [11:0]     bus_wdata;
  logic            ld_fire;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [11:0]     mem_wdata;
  logic            unused_bits;

  assign rw        = bus_in[11];
  assign commit    = bus_in[10];
  assign addr_data = bus_in[9:0];
  assign bus_addr  = addr_data[AW-1:0];

  // Upper address bits alias away when DEPTH is below 1024.
  assign unused_bits = ^{bus_in, ld_addr};

  // Zero-latency read; a write on this edge shows up on the next cycle.
  assign bus_out  = (state == IDLE) ? mem[bus_addr] : mem[addr_q];
  assign ld_ready = (state == IDLE) && rw;
  assign ld_fire  = ld_valid && ld_ready;

  always_comb begin
    bus_we    = 1'b0;
    bus_wdata = '0;
`ifdef MEM_BUS_WIDE_WRITE_EN
    if (state == DATA_LO && !rw && commit) begin
      bus_we    = 1'b1;
      bus_wdata = {addr_data[5:0], lo_q};
    end
`else
    if (state == ADDR_HELD && !rw && commit) begin
      bus_we    = 1'b1;
      bus_wdata = {6'b0, addr_data[5:0]};
    end
`endif
  end

  // Preload only fires in IDLE and bus stores never commit from IDLE, so they never collide.
  assign mem_we    = bus_we || ld_fire;
  assign mem_waddr = ld_fire ? ld_addr[AW-1:0] : addr_q;
  assign mem_wdata = ld_fire ? ld_data : bus_wdata;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      proto_err <= 1'b0;
      store_cnt <= '0;
`ifdef MEM_BUS_WIDE_WRITE_EN
      lo_q      <= '0;
`endif
    end else begin
      if (bus_we && (store_cnt != '1)) begin
        store_cnt <= store_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (!rw) begin
            if (commit) begin
              proto_err <= 1'b1;
            end else begin
              addr_q <= bus_addr;
              state  <= ADDR_HELD;
            end
          end
        end
        ADDR_HELD: begin
          if (rw) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else if (commit) begin
`ifdef MEM_BUS_WIDE_WRITE_EN
            lo_q  <= addr_data[5:0];
            state <= DATA_LO;
`else
            state <= IDLE;
`endif
          end else begin
            addr_q <= bus_addr;
          end
        end
`ifdef MEM_BUS_WIDE_WRITE_EN
        DATA_LO: begin
          if (rw) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else if (commit) begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: directed cases plus randomized traffic against a
// behavioural model; a second instance (DEPTH=64, CNT_W=2) covers aliasing and saturation.
module tb_mem_bus_bridge;

  logic        clock;
  logic        reset;
  logic [11:0] bus_in;
  logic        ld_valid;
  logic [9:0]  ld_addr;
  logic [11:0] ld_data;

  logic [11:0] bus_out0, bus_out1;
  logic        ld_ready0, ld_ready1;
  logic        proto_err0, proto_err1;
  logic [15:0] store_cnt0;
  logic [1:0]  store_cnt1;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  mem_bus_bridge #(.DEPTH(1024), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .bus_in(bus_in), .bus_out(bus_out0),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready0),
    .proto_err(proto_err0), .store_cnt(store_cnt0)
  );

  mem_bus_bridge #(.DEPTH(64), .CNT_W(2)) dut_s (
    .clock(clock), .reset(reset), .bus_in(bus_in), .bus_out(bus_out1),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready1),
    .proto_err(proto_err1), .store_cnt(store_cnt1)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Behavioural model: pend counts beats of the store in flight (0 none, 1 address, 2 low half).
  int mem_m [2][1024];
  bit known_m [2][1024];
  int pend_m [2];
  int addr_m [2];
  int lo_m [2];
  int err_m [2];
  int cnt_m [2];
  int dep [2] = '{1024, 64};
  int cmax [2] = '{65535, 3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_write(input int i, input int a, input int d);
    mem_m[i][a] = d & 12'hFFF;
    known_m[i][a] = 1;
    if (cnt_m[i] < cmax[i]) cnt_m[i] = cnt_m[i] + 1;
  endfunction

  int ea, rw_b, cm_b, ad;
  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        pend_m[i] = 0; addr_m[i] = 0; lo_m[i] = 0; err_m[i] = 0; cnt_m[i] = 0;
      end
    end
    rw_b = int'(bus_in[11]);
    cm_b = int'(bus_in[10]);
    ad   = int'(bus_in[9:0]);
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        ea = (pend_m[i] == 0) ? (ad % dep[i]) : addr_m[i];
        if (known_m[i][ea])
          chk(i == 0 ? "bus_out" : "bus_out_s", i == 0 ? int'(bus_out0) : int'(bus_out1), mem_m[i][ea]);
        chk(i == 0 ? "ld_ready" : "ld_ready_s", i == 0 ? int'(ld_ready0) : int'(ld_ready1),
            (pend_m[i] == 0 && rw_b == 1) ? 1 : 0);
        chk(i == 0 ? "proto_err" : "proto_err_s", i == 0 ? int'(proto_err0) : int'(proto_err1), err_m[i]);
        chk(i == 0 ? "store_cnt" : "store_cnt_s", i == 0 ? int'(store_cnt0) : int'(store_cnt1), cnt_m[i]);
      end
    end
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (ld_valid && pend_m[i] == 0 && rw_b == 1) begin
          mem_m[i][int'(ld_addr) % dep[i]] = int'(ld_data);
          known_m[i][int'(ld_addr) % dep[i]] = 1;
        end
        case (pend_m[i])
          0: if (rw_b == 0) begin
               if (cm_b == 1) err_m[i] = 1;
               else begin pend_m[i] = 1; addr_m[i] = ad % dep[i]; end
             end
          1: if (rw_b == 1) begin err_m[i] = 1; pend_m[i] = 0; end
             else if (cm_b == 1) begin
`ifdef MEM_BUS_WIDE_WRITE_EN
               lo_m[i] = ad % 64; pend_m[i] = 2;
`else
               model_write(i, addr_m[i], ad % 64); pend_m[i] = 0;
`endif
             end else addr_m[i] = ad % dep[i];
          default: if (rw_b == 1) begin err_m[i] = 1; pend_m[i] = 0; end
             else if (cm_b == 1) begin
               model_write(i, addr_m[i], (ad % 64) * 64 + lo_m[i]); pend_m[i] = 0;
             end
        endcase
      end
    end
  end

  task automatic drive(input logic [11:0] b, input logic v, input logic [9:0] a, input logic [11:0] d);
    @(posedge clock);
    #1;
    bus_in = b; ld_valid = v; ld_addr = a; ld_data = d;
  endtask

  // Asserts reset mid-cycle and checks its effect before any clock edge.
  task automatic apply_reset(input logic [11:0] b);
    @(posedge clock);
    #1;
    bus_in = b; ld_valid = 0;
    #2 reset = 1;
    #1;
    chk("arst_proto_err", int'(proto_err0), 0);
    chk("arst_store_cnt", int'(store_cnt0), 0);
    chk("arst_ld_ready", int'(ld_ready0), int'(b[11]));
    chk("arst_store_cnt_s", int'(store_cnt1), 0);
    @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic bus_store(input logic [9:0] a, input logic [11:0] d);
    drive({2'b00, a}, 0, 10'h0, 12'h0);
`ifdef MEM_BUS_WIDE_WRITE_EN
    drive({2'b01, 4'h0, d[5:0]}, 0, 10'h0, 12'h0);
    drive({2'b01, 4'h0, d[11:6]}, 0, 10'h0, 12'h0);
`else
    drive({2'b01, 4'h0, d[5:0]}, 0, 10'h0, 12'h0);
`endif
  endtask

  initial begin
    reset = 1; bus_in = 12'h800; ld_valid = 0; ld_addr = 0; ld_data = 0;
    repeat (2) @(posedge clock);
    #1 check_en = 1;
    @(negedge clock);
    chk("rst_proto_err", int'(proto_err0), 0);
    chk("rst_store_cnt", int'(store_cnt0), 0);
    chk("rst_ld_ready", int'(ld_ready0), 1);
    @(posedge clock);
    #1 reset = 0;

    // Fill both memories with a known pattern: word a holds (7a+3) mod 4096.
    for (int a = 0; a < 1024; a++) drive(12'h800, 1, a[9:0], 12'(a * 7 + 3));

    // Preload then read back.
    drive(12'h805, 1, 10'h005, 12'hABC);
    @(negedge clock);
    chk("pre_ld_ready", int'(ld_ready0), 1);
    drive(12'h805, 0, 10'h0, 12'h0);
    @(negedge clock);
    chk("pre_read", int'(bus_out0), 12'hABC);
    chk("pre_no_store", int'(store_cnt0), 0);

`ifdef MEM_BUS_WIDE_WRITE_EN
    drive(12'h3FF, 1, 10'h3FF, 12'hFFF);
    @(negedge clock);
    chk("wide_ready0", int'(ld_ready0), 0);
    drive(12'h415, 1, 10'h3FF, 12'hFFF);
    @(negedge clock);
    chk("wide_ready1", int'(ld_ready0), 0);
    drive(12'h42A, 1, 10'h3FF, 12'hFFF);
    @(negedge clock);
    chk("wide_ready2", int'(ld_ready0), 0);
    chk("wide_old", int'(bus_out0), 12'hBFC);
    drive(12'hBFF, 0, 10'h0, 12'h0);
    @(negedge clock);
    chk("wide_read", int'(bus_out0), 12'hA95);
    chk("wide_cnt", int'(store_cnt0), 1);
`else
    drive(12'h010, 1, 10'h010, 12'hFFF);
    @(negedge clock);
    chk("narrow_ready", int'(ld_ready0), 0);
    drive(12'h42A, 0, 10'h0, 12'h0);
    @(negedge clock);
    chk("narrow_old", int'(bus_out0), 12'h073);
    chk("narrow_cnt_pre", int'(store_cnt0), 0);
    drive(12'h810, 0, 10'h0, 12'h0);
    @(negedge clock);
    chk("narrow_read", int'(bus_out0), 12'h02A);
    chk("narrow_cnt", int'(store_cnt0), 1);
`endif

    // Commit beat in IDLE.
    drive(12'h400, 0, 10'h0, 12'h0);
    @(negedge clock);
    chk("err_idle_pre", int'(proto_err0), 0);
    drive(12'h800, 0, 10'h0, 12'h0);
    @(negedge clock);
    chk("err_idle", int'(proto_err0), 1);
    chk("err_idle_cnt", int'(store_cnt0), 1);
    chk("err_idle_mem", int'(bus_out0), 12'h003);

    // Reset between address and commit beats discards the partial store.
    drive(12'h020, 0, 10'h0, 12'h0);
    @(negedge clock);
    apply_reset(12'h805);
    @(negedge clock);
    chk("mid_rst_idle", int'(bus_out0), 12'hABC);
    drive(12'h42A, 0, 10'h0, 12'h0);
    drive(12'h820, 0, 10'h0, 12'h0);
    @(negedge clock);
    chk("mid_rst_err", int'(proto_err0), 1);
    chk("mid_rst_cnt", int'(store_cnt0), 0);
    chk("mid_rst_mem", int'(bus_out0), 12'h0E3);

    // Read beat aborting a store.
    apply_reset(12'h800);
    drive(12'h020, 0, 10'h0, 12'h0);
    drive(12'h820, 0, 10'h0, 12'h0);
    @(negedge clock);
    chk("abort_err_pre", int'(proto_err0), 0);
    drive(12'h805, 0, 10'h0, 12'h0);
    @(negedge clock);
    chk("abort_err", int'(proto_err0), 1);
    chk("abort_idle", int'(ld_ready0), 1);
    chk("abort_cnt", int'(store_cnt0), 0);

    // Saturation of the 2-bit counter.
    apply_reset(12'h800);
    for (int k = 0; k < 5; k++) bus_store(10'($urandom_range(0, 1023)), 12'($urandom));
    drive(12'h800, 0, 10'h0, 12'h0);
    @(negedge clock);
    chk("sat_cnt_wide", int'(store_cnt0), 5);
    chk("sat_cnt_2bit", int'(store_cnt1), 3);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        apply_reset({2'b10, 10'($urandom_range(0, 1023))});
      end else begin
        drive({($urandom_range(0, 3) == 0), 1'($urandom), 10'($urandom_range(0, 1023))},
              1'($urandom), 10'($urandom_range(0, 1023)), 12'($urandom));
      end
    end

    drive(12'h800, 0, 10'h0, 12'h0);
    repeat (2) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
